// File: rtl/tl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tl_pkg
//  Description : Shared types and constants for the intersection scheduler:
//                phase state encoding, lamp triple and road select values.
//                The FLASH state exists only when TL_FLASH_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
package tl_pkg;

    // Phase states of the scheduler FSM
    typedef enum logic [2:0] {
        ALLRED_A  = 3'd0,
        NS_GREEN  = 3'd1,
        NS_YELLOW = 3'd2,
        ALLRED_B  = 3'd3,
        EW_GREEN  = 3'd4,
        EW_YELLOW = 3'd5,
        PED_WALK  = 3'd6
`ifdef TL_FLASH_EN
        ,
        FLASH     = 3'd7
`endif
    } state_t;

    // One road's lamp set
    typedef struct packed {
        logic red;
        logic yellow;
        logic green;
    } lamp_t;

    // Road select values used by the walk-return flag
    localparam logic c_road_ns = 1'b0;
    localparam logic c_road_ew = 1'b1;

    // Safe default for a road: red only
    localparam lamp_t c_lamp_red = 3'b100;

    // Build a lamp triple from individual bits
    function automatic lamp_t lamp_set(input logic r, input logic y, input logic g);
        lamp_t l;
        l.red    = r;
        l.yellow = y;
        l.green  = g;
        return l;
    endfunction

endpackage
`default_nettype wire

// File: rtl/phase_timer.sv
`default_nettype none
// ============================================================================
//  Module      : phase_timer
//  Description : Phase cycle counter. Cleared on request, otherwise counts up
//                each cycle and saturates at all-ones. Flags when the count
//                equals the supplied terminal value.
//  Revision    : 1.0 - initial release
// ============================================================================
module phase_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic [CNT_W-1:0] term,
    output logic [CNT_W-1:0] cnt,
    output logic             done
);

    logic [CNT_W-1:0] r_cnt;

    // Count cycles in the current phase; restart on clear, hold at all-ones
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (clear) begin
            r_cnt <= '0;
        end else if (r_cnt != {CNT_W{1'b1}}) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign cnt  = r_cnt;
    assign done = (r_cnt == term);

endmodule
`default_nettype wire

// File: rtl/intersection_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : intersection_scheduler
//  Description : Demand-driven phase scheduler for a two-road intersection
//                with a pedestrian walk phase. Greens extend while there is
//                no opposing demand and are cut once demand appears after
//                the minimum green. All lamp outputs are registered.
//                Optional feature macro: TL_FLASH_EN (flashing-yellow mode
//                selected by input flash_req).
//  Revision    : 1.0 - initial release
// ============================================================================
module intersection_scheduler
    import tl_pkg::*;
#(
    parameter int CNT_W     = 8,
    parameter int GREEN_MIN = 4,
    parameter int GREEN_MAX = 10,
    parameter int YELLOW_T  = 2,
    parameter int ALLRED_T  = 1,
    parameter int WALK_T    = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic ns_car,
    input  logic ew_car,
    input  logic ped_req,
`ifdef TL_FLASH_EN
    input  logic flash_req,
`endif
    output logic ns_red,
    output logic ns_yellow,
    output logic ns_green,
    output logic ew_red,
    output logic ew_yellow,
    output logic ew_green,
    output logic walk,
    output logic ped_pending
);

    // Terminal counts (phase lengths minus one)
    localparam logic [CNT_W-1:0] c_green_min_m1 = CNT_W'(GREEN_MIN - 1);
    localparam logic [CNT_W-1:0] c_green_max_m1 = CNT_W'(GREEN_MAX - 1);
    localparam logic [CNT_W-1:0] c_yellow_m1    = CNT_W'(YELLOW_T - 1);
    localparam logic [CNT_W-1:0] c_allred_m1    = CNT_W'(ALLRED_T - 1);
    localparam logic [CNT_W-1:0] c_walk_m1      = CNT_W'(WALK_T - 1);

    // Reject timing parameters that are zero, inverted or do not fit the counter
    generate
        if (GREEN_MIN < 1 || GREEN_MAX < GREEN_MIN || YELLOW_T < 1 ||
            ALLRED_T < 1 || WALK_T < 1 || CNT_W < 1 || CNT_W > 30 ||
            GREEN_MAX > (1 << CNT_W) || YELLOW_T > (1 << CNT_W) ||
            ALLRED_T > (1 << CNT_W) || WALK_T > (1 << CNT_W)) begin : g_bad_params
            $error("intersection_scheduler: illegal timing parameters");
        end
    endgenerate

    state_t           r_state;
    state_t           w_state_next;
    logic             r_ped_pending;
    logic             w_ped_next;
    logic             r_walk_ret;
    logic             w_walk_ret_next;
    logic [CNT_W-1:0] w_cnt;
    logic [CNT_W-1:0] w_term;
    logic             w_done;
    logic             w_timer_clear;
    logic             w_green_cut_ns;
    logic             w_green_cut_ew;
    lamp_t            r_ns_lamp;
    lamp_t            r_ew_lamp;
    logic             r_walk;
    lamp_t            w_ns_lamp;
    lamp_t            w_ew_lamp;
    logic             w_walk;

    phase_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk   (clk),
        .reset (reset),
        .clear (w_timer_clear),
        .term  (w_term),
        .cnt   (w_cnt),
        .done  (w_done)
    );

    // Early green cut: minimum served and the opposing side is asking
    assign w_green_cut_ns = (w_cnt >= c_green_min_m1) && (ew_car || r_ped_pending);
    assign w_green_cut_ew = (w_cnt >= c_green_min_m1) && (ns_car || r_ped_pending);

    // Select the terminal count for the current phase
    always_comb begin
        w_term = c_allred_m1;
        case (r_state)
            NS_GREEN, EW_GREEN:   w_term = c_green_max_m1;
            NS_YELLOW, EW_YELLOW: w_term = c_yellow_m1;
            PED_WALK:             w_term = c_walk_m1;
`ifdef TL_FLASH_EN
            FLASH:                w_term = c_yellow_m1;
`endif
            default:              w_term = c_allred_m1;
        endcase
    end

    // Next-state selection
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ALLRED_A:  if (w_done) w_state_next = r_ped_pending ? PED_WALK : NS_GREEN;
            NS_GREEN:  if (w_green_cut_ns || w_done) w_state_next = NS_YELLOW;
            NS_YELLOW: if (w_done) w_state_next = ALLRED_B;
            ALLRED_B:  if (w_done) w_state_next = r_ped_pending ? PED_WALK : EW_GREEN;
            EW_GREEN:  if (w_green_cut_ew || w_done) w_state_next = EW_YELLOW;
            EW_YELLOW: if (w_done) w_state_next = ALLRED_A;
            PED_WALK:  if (w_done) w_state_next = (r_walk_ret == c_road_ew) ? EW_GREEN : NS_GREEN;
`ifdef TL_FLASH_EN
            FLASH:     if (!flash_req) w_state_next = ALLRED_A;
`endif
            default:   w_state_next = ALLRED_A;
        endcase
`ifdef TL_FLASH_EN
        if (flash_req) w_state_next = FLASH;
`endif
    end

    // Pedestrian latch: cleared when the walk starts, a new press wins
    always_comb begin
        w_ped_next = r_ped_pending;
        if (w_state_next == PED_WALK && r_state != PED_WALK) w_ped_next = 1'b0;
        if (ped_req) w_ped_next = 1'b1;
    end

    // Remember which all-red fed the walk so the walk returns to that road
    always_comb begin
        w_walk_ret_next = r_walk_ret;
        if (w_state_next == PED_WALK && r_state == ALLRED_A) w_walk_ret_next = c_road_ns;
        if (w_state_next == PED_WALK && r_state == ALLRED_B) w_walk_ret_next = c_road_ew;
    end

`ifdef TL_FLASH_EN
    logic r_flash_on;
    logic w_flash_on_next;
    logic w_flash_toggle;

    assign w_flash_toggle = (r_state == FLASH) && (w_state_next == FLASH) && w_done;
    assign w_timer_clear  = (w_state_next != r_state) || w_flash_toggle;

    // Flash phase bit: lit on entry, inverted every YELLOW_T cycles
    always_comb begin
        w_flash_on_next = r_flash_on;
        if (w_state_next == FLASH && r_state != FLASH) w_flash_on_next = 1'b1;
        else if (w_flash_toggle)                       w_flash_on_next = ~r_flash_on;
    end

    // Flash phase register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_flash_on <= 1'b0;
        else       r_flash_on <= w_flash_on_next;
    end
`else
    assign w_timer_clear = (w_state_next != r_state);
`endif

    // Lamp decode of the upcoming state so registered lamps track the state
    always_comb begin
        w_ns_lamp = c_lamp_red;
        w_ew_lamp = c_lamp_red;
        w_walk    = 1'b0;
        case (w_state_next)
            NS_GREEN:  w_ns_lamp = lamp_set(1'b0, 1'b0, 1'b1);
            NS_YELLOW: w_ns_lamp = lamp_set(1'b0, 1'b1, 1'b0);
            EW_GREEN:  w_ew_lamp = lamp_set(1'b0, 1'b0, 1'b1);
            EW_YELLOW: w_ew_lamp = lamp_set(1'b0, 1'b1, 1'b0);
            PED_WALK:  w_walk    = 1'b1;
`ifdef TL_FLASH_EN
            FLASH: begin
                w_ns_lamp = lamp_set(1'b0, w_flash_on_next, 1'b0);
                w_ew_lamp = lamp_set(1'b0, w_flash_on_next, 1'b0);
            end
`endif
            default: ;
        endcase
    end

    // State, latches and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= ALLRED_A;
            r_ped_pending <= 1'b0;
            r_walk_ret    <= c_road_ns;
            r_ns_lamp     <= c_lamp_red;
            r_ew_lamp     <= c_lamp_red;
            r_walk        <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_ped_pending <= w_ped_next;
            r_walk_ret    <= w_walk_ret_next;
            r_ns_lamp     <= w_ns_lamp;
            r_ew_lamp     <= w_ew_lamp;
            r_walk        <= w_walk;
        end
    end

    assign ns_red      = r_ns_lamp.red;
    assign ns_yellow   = r_ns_lamp.yellow;
    assign ns_green    = r_ns_lamp.green;
    assign ew_red      = r_ew_lamp.red;
    assign ew_yellow   = r_ew_lamp.yellow;
    assign ew_green    = r_ew_lamp.green;
    assign walk        = r_walk;
    assign ped_pending = r_ped_pending;

endmodule
`default_nettype wire

// File: tb/tb_intersection_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_intersection_scheduler
//  Description : Directed self-checking bench for intersection_scheduler with
//                default parameters. Flash checks compile in with TL_FLASH_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_intersection_scheduler;

    // Lamp vector: {ns_r, ns_y, ns_g, ew_r, ew_y, ew_g, walk}
    localparam logic [6:0] c_l_allred = 7'b100_100_0;
    localparam logic [6:0] c_l_nsg    = 7'b001_100_0;
    localparam logic [6:0] c_l_nsy    = 7'b010_100_0;
    localparam logic [6:0] c_l_ewg    = 7'b100_001_0;
    localparam logic [6:0] c_l_ewy    = 7'b100_010_0;
    localparam logic [6:0] c_l_walk   = 7'b100_100_1;
    localparam logic [6:0] c_l_fl_on  = 7'b010_010_0;
    localparam logic [6:0] c_l_fl_off = 7'b000_000_0;

    logic clk = 1'b0;
    logic reset;
    logic ns_car, ew_car, ped_req;
    logic ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green, walk, ped_pending;
`ifdef TL_FLASH_EN
    logic flash_req;
`endif
    logic [6:0] w_obs;

    int n_checks = 0;
    int n_errors = 0;

    intersection_scheduler dut (
        .clk         (clk),
        .reset       (reset),
        .ns_car      (ns_car),
        .ew_car      (ew_car),
        .ped_req     (ped_req),
`ifdef TL_FLASH_EN
        .flash_req   (flash_req),
`endif
        .ns_red      (ns_red),
        .ns_yellow   (ns_yellow),
        .ns_green    (ns_green),
        .ew_red      (ew_red),
        .ew_yellow   (ew_yellow),
        .ew_green    (ew_green),
        .walk        (walk),
        .ped_pending (ped_pending)
    );

    assign w_obs = {ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green, walk};

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expect a lamp pattern for n consecutive cycles, then move past them
    task automatic run_phase(input string tag, input logic [6:0] lamps, input int n);
        for (int i = 0; i < n; i++) begin
            check(tag, 32'(w_obs), 32'(lamps));
            tick();
        end
    endtask

    initial begin
        reset   = 1'b1;
        ns_car  = 1'b0;
        ew_car  = 1'b0;
        ped_req = 1'b0;
`ifdef TL_FLASH_EN
        flash_req = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        check("reset_lamps", 32'(w_obs), 32'(c_l_allred));
        check("reset_ped", 32'(ped_pending), 32'd0);
        reset = 1'b0;

        // No demand: 1/10/2/1/10/2/1 then NS green again
        run_phase("t1_allred_a", c_l_allred, 1);
        run_phase("t1_nsg", c_l_nsg, 10);
        run_phase("t1_nsy", c_l_nsy, 2);
        run_phase("t1_allred_b", c_l_allred, 1);
        run_phase("t1_ewg", c_l_ewg, 10);
        run_phase("t1_ewy", c_l_ewy, 2);
        run_phase("t1_allred_a2", c_l_allred, 1);

        // ew_car held from NS green cnt 0: green cut after 4 cycles
        ew_car = 1'b1;
        run_phase("t2_nsg", c_l_nsg, 4);
        ew_car = 1'b0;
        run_phase("t2_nsy", c_l_nsy, 2);
        run_phase("t2_allred_b", c_l_allred, 1);
        run_phase("t2_ewg", c_l_ewg, 10);
        run_phase("t2_ewy", c_l_ewy, 2);
        run_phase("t2_allred_a", c_l_allred, 1);

        // ew_car pulse at cnt 1 only: ignored, full 10-cycle green
        run_phase("t3_nsg_c0", c_l_nsg, 1);
        ew_car = 1'b1;
        run_phase("t3_nsg_c1", c_l_nsg, 1);
        ew_car = 1'b0;
        run_phase("t3_nsg_rest", c_l_nsg, 8);
        run_phase("t3_nsy", c_l_nsy, 2);
        run_phase("t3_allred_b", c_l_allred, 1);
        run_phase("t3_ewg", c_l_ewg, 10);
        run_phase("t3_ewy", c_l_ewy, 2);
        run_phase("t3_allred_a", c_l_allred, 1);

        // ped_req pulse at cnt 2: green cut at 4, walk after ALLRED_B, back to EW
        run_phase("t4_nsg_c01", c_l_nsg, 2);
        ped_req = 1'b1;
        run_phase("t4_nsg_c2", c_l_nsg, 1);
        ped_req = 1'b0;
        check("t4_ped_set", 32'(ped_pending), 32'd1);
        run_phase("t4_nsg_c3", c_l_nsg, 1);
        run_phase("t4_nsy", c_l_nsy, 2);
        run_phase("t4_allred_b", c_l_allred, 1);
        check("t4_ped_cleared", 32'(ped_pending), 32'd0);
        run_phase("t4_walk", c_l_walk, 3);
        run_phase("t4_ewg", c_l_ewg, 10);
        run_phase("t4_ewy", c_l_ewy, 2);
        run_phase("t4_allred_a", c_l_allred, 1);

        // ped_req on the walk-entry cycle: request survives, walk repeats via ALLRED_A
        ped_req = 1'b1;
        run_phase("t5_nsg_c0", c_l_nsg, 1);
        ped_req = 1'b0;
        run_phase("t5_nsg", c_l_nsg, 3);
        run_phase("t5_nsy", c_l_nsy, 2);
        ped_req = 1'b1;
        run_phase("t5_allred_b", c_l_allred, 1);
        ped_req = 1'b0;
        check("t5_ped_kept", 32'(ped_pending), 32'd1);
        run_phase("t5_walk1", c_l_walk, 3);
        run_phase("t5_ewg", c_l_ewg, 4);
        run_phase("t5_ewy", c_l_ewy, 2);
        run_phase("t5_allred_a", c_l_allred, 1);
        check("t5_ped_clr2", 32'(ped_pending), 32'd0);
        run_phase("t5_walk2", c_l_walk, 3);
        run_phase("t5_nsg_ret", c_l_nsg, 10);
        run_phase("t5_nsy2", c_l_nsy, 2);
        run_phase("t5_allred_b2", c_l_allred, 1);

        // Asynchronous reset in the middle of EW green
        run_phase("t6_ewg", c_l_ewg, 5);
        #3;
        reset = 1'b1;
        #1;
        check("t6_async_lamps", 32'(w_obs), 32'(c_l_allred));
        check("t6_async_ped", 32'(ped_pending), 32'd0);
        tick();
        check("t6_held_lamps", 32'(w_obs), 32'(c_l_allred));
        reset = 1'b0;
        run_phase("t6_allred_a", c_l_allred, 1);
        run_phase("t6_nsg", c_l_nsg, 10);
        run_phase("t6_nsy", c_l_nsy, 2);
        run_phase("t6_allred_b", c_l_allred, 1);

`ifdef TL_FLASH_EN
        // Flash during EW green: yellows lit 2, dark 2, lit; release -> ALLRED_A -> NS
        run_phase("t7_ewg", c_l_ewg, 3);
        flash_req = 1'b1;
        ped_req   = 1'b1;
        run_phase("t7_ewg_req", c_l_ewg, 1);
        ped_req   = 1'b0;
        run_phase("t7_fl_on", c_l_fl_on, 2);
        check("t7_ped_latched", 32'(ped_pending), 32'd1);
        run_phase("t7_fl_off", c_l_fl_off, 2);
        flash_req = 1'b0;
        run_phase("t7_fl_on2", c_l_fl_on, 1);
        run_phase("t7_allred_a", c_l_allred, 1);
        run_phase("t7_walk", c_l_walk, 3);
        run_phase("t7_nsg", c_l_nsg, 2);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Guard against a stuck run
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
